// File: rtl/arith_mp_seq.sv
// rtl/arith_mp_seq.sv - multi-word streaming ADD/SUB/SHL/SHR with chained carry
// Optional signed-overflow flag is built only when ARITH_SEQ_OVF_EN is defined.
module arith_mp_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [MAX_LEN_W-1:0]  cmd_len,
    input  logic                  cmd_cin,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done_carry,
    output logic                  done_zero,
    output logic                  done_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_SHL = 2'd2;
    localparam logic [1:0] OP_SHR = 2'd3;
    localparam int         MSB    = DATA_WIDTH - 1;

    state_t                state;
    logic [1:0]            op_q;
    logic [MAX_LEN_W-1:0]  len_q;
    logic [MAX_LEN_W-1:0]  cnt;
    logic                  carry;
    logic                  zero_acc;

    logic                  in_fire;
    logic                  last_word;
    logic                  zero_next;
    logic [DATA_WIDTH-1:0] res;
    logic                  next_c;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH:0]   diff_ext;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign last_word = (cnt == len_q);

    // The extra top bit of each extended result is the carry / borrow out of the word.
    assign sum_ext  = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, carry};
    assign diff_ext = {1'b0, in_a} - {1'b0, in_b} - {{DATA_WIDTH{1'b0}}, carry};

    always_comb begin
        res    = '0;
        next_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                res    = sum_ext[MSB:0];
                next_c = sum_ext[DATA_WIDTH];
            end
            OP_SUB: begin
                res    = diff_ext[MSB:0];
                next_c = diff_ext[DATA_WIDTH];
            end
            OP_SHL: begin
                res    = {in_a[MSB-1:0], carry};
                next_c = in_a[MSB];
            end
            default: begin
                res    = {carry, in_a[MSB:1]};
                next_c = in_a[0];
            end
        endcase
    end

    assign zero_next = zero_acc && (res == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_ADD;
            len_q      <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            zero_acc   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            done_carry <= 1'b0;
            done_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        len_q    <= cmd_len;
                        carry    <= cmd_cin;
                        cnt      <= '0;
                        zero_acc <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        out_data  <= res;
                        out_valid <= 1'b1;
                        out_last  <= last_word;
                        carry     <= next_c;
                        cnt       <= cnt + {{(MAX_LEN_W-1){1'b0}}, 1'b1};
                        zero_acc  <= zero_next;
                        if (last_word) begin
                            done_carry <= next_c;
                            done_zero  <= zero_next;
                            state      <= FLUSH;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Only the final word can be pending here; its handshake ends the op.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARITH_SEQ_OVF_EN
    logic ovf_word;
    logic ovf_q;

    always_comb begin
        ovf_word = 1'b0;
        case (op_q)
            OP_ADD:  ovf_word = (in_a[MSB] == in_b[MSB]) && (res[MSB] != in_a[MSB]);
            OP_SUB:  ovf_word = (in_a[MSB] != in_b[MSB]) && (res[MSB] != in_a[MSB]);
            default: ovf_word = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && in_fire && last_word) begin
            ovf_q <= ovf_word;
        end
    end

    assign done_ovf = ovf_q;
`else
    assign done_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_arith_mp_seq.sv
// tb/tb_arith_mp_seq.sv - randomized and directed check of arith_mp_seq against a wide-integer model
module tb_arith_mp_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_len = 4'd0;
    logic       cmd_cin = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       done_carry;
    logic       done_zero;
    logic       done_ovf;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] word_a [16];
    logic [7:0] word_b [16];
    logic [7:0] exp_out [16];
    logic       exp_c, exp_z, exp_v;
    logic [7:0] first_data, last_data;
    logic       last_c, last_z, last_v;

    arith_mp_seq #(.DATA_WIDTH(8), .MAX_LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_cin(cmd_cin),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done_carry(done_carry), .done_zero(done_zero),
        .done_ovf(done_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Whole operands as wide integers; SHR streams most-significant word first.
    task automatic compute_model(input logic [1:0] op, input int n, input logic cin);
        logic [135:0] a_v, b_v, r_v, mask, cin_v;
        int nb, pos;
        nb = n * 8;
        a_v = '0;
        b_v = '0;
        cin_v = {135'd0, cin};
        for (int k = 0; k < n; k++) begin
            pos = (op == 2'd3) ? (n - 1 - k) : k;
            a_v = a_v | ({128'd0, word_a[k]} << (8 * pos));
            b_v = b_v | ({128'd0, word_b[k]} << (8 * pos));
        end
        mask = (136'd1 << nb) - 136'd1;
        case (op)
            2'd0: begin r_v = a_v + b_v + cin_v; exp_c = r_v[nb]; end
            2'd1: begin r_v = a_v - b_v - cin_v; exp_c = (a_v < (b_v + cin_v)); end
            2'd2: begin r_v = (a_v << 1) | cin_v; exp_c = a_v[nb-1]; end
            default: begin r_v = (a_v >> 1) | (cin_v << (nb - 1)); exp_c = a_v[0]; end
        endcase
        r_v = r_v & mask;
        exp_z = (r_v == '0);
        exp_v = 1'b0;
`ifdef ARITH_SEQ_OVF_EN
        if (op == 2'd0)
            exp_v = (a_v[nb-1] == b_v[nb-1]) && (r_v[nb-1] != a_v[nb-1]);
        else if (op == 2'd1)
            exp_v = (a_v[nb-1] != b_v[nb-1]) && (r_v[nb-1] != a_v[nb-1]);
`endif
        for (int k = 0; k < n; k++) begin
            pos = (op == 2'd3) ? (n - 1 - k) : k;
            exp_out[k] = r_v[8*pos +: 8];
        end
    endtask

    // mode 0: no back-pressure; 1: random valid/ready; 2: three-cycle out_ready stall on word 1
    task automatic run_op(input logic [1:0] op, input int n, input logic cin, input int mode);
        int in_idx, out_idx, cyc, stall_cnt;
        logic exp_ov, run, fin, exp_ir, in_fire, out_fire, prev_stall;
        logic [7:0] hold_d;
        compute_model(op, n, cin);
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_len = 4'(n - 1);
        cmd_cin = cin;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        in_idx = 0; out_idx = 0; cyc = 0; stall_cnt = 0;
        exp_ov = 1'b0; run = 1'b1; fin = 1'b0; prev_stall = 1'b0; hold_d = 8'd0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            chk("run_busy", busy, 1);
            chk("run_cmd_ready", cmd_ready, 0);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov && out_valid) begin
                chk("out_data", out_data, exp_out[out_idx]);
                chk("out_last", out_last, out_idx == n - 1);
                if (prev_stall) chk("stall_hold", out_data, hold_d);
                if (out_idx == 0) first_data = out_data;
                if (out_idx == n - 1) begin
                    chk("done_carry", done_carry, exp_c);
                    chk("done_zero", done_zero, exp_z);
                    chk("done_ovf", done_ovf, exp_v);
                    last_data = out_data;
                    last_c = done_carry;
                    last_z = done_zero;
                    last_v = done_ovf;
                end
            end
            out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 2 && exp_ov && out_idx == 1 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            if (in_idx < n) begin
                in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_a = word_a[in_idx];
                in_b = word_b[in_idx];
            end else begin
                in_valid = 1'($urandom);
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            #1;
            exp_ir = run && (!exp_ov || out_ready);
            chk("in_ready", in_ready, exp_ir);
            in_fire = in_valid && exp_ir;
            out_fire = exp_ov && out_ready;
            prev_stall = exp_ov && !out_ready;
            hold_d = out_data;
            if (out_fire) begin
                if (out_idx == n - 1) fin = 1'b1;
                out_idx++;
            end
            if (in_fire) begin
                in_idx++;
                if (in_idx == n) run = 1'b0;
                exp_ov = 1'b1;
            end else if (out_fire) begin
                exp_ov = 1'b0;
            end
            cyc++;
        end
        if (!fin) chk("op_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("end_cmd_ready", cmd_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_out_valid", out_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_flags", {done_carry, done_zero, done_ovf}, 0);

        word_a[0] = 8'hFF; word_b[0] = 8'h01; word_a[1] = 8'h01; word_b[1] = 8'h00;
        run_op(2'd0, 2, 1'b0, 0);
        chk("add2_w0", first_data, 8'h00);
        chk("add2_w1", last_data, 8'h02);
        chk("add2_cz", {last_c, last_z}, 2'b00);

        word_a[0] = 8'h00; word_b[0] = 8'h01;
        run_op(2'd1, 1, 1'b0, 0);
        chk("sub1_data", last_data, 8'hFF);
        chk("sub1_czv", {last_c, last_z, last_v}, 3'b100);

        word_a[0] = 8'h80; word_a[1] = 8'h01; word_b[0] = 8'h00; word_b[1] = 8'h00;
        run_op(2'd2, 2, 1'b1, 0);
        chk("shl_w0", first_data, 8'h01);
        chk("shl_w1", last_data, 8'h03);
        chk("shl_c", last_c, 0);

        word_a[0] = 8'h01;
        run_op(2'd3, 1, 1'b1, 0);
        chk("shr_data", last_data, 8'h80);
        chk("shr_c", last_c, 1);

        word_a[0] = 8'h7F; word_b[0] = 8'h01;
        run_op(2'd0, 1, 1'b0, 0);
        chk("ovf_data", last_data, 8'h80);
`ifdef ARITH_SEQ_OVF_EN
        chk("ovf_flag", last_v, 1);
`else
        chk("ovf_flag", last_v, 0);
`endif

        for (int k = 0; k < 4; k++) begin
            word_a[k] = 8'($urandom);
            word_b[k] = 8'($urandom);
        end
        for (int m = 0; m < 4; m++) run_op(2'(m), 4, 1'b1, 2);

        for (int k = 0; k < 16; k++) begin
            word_a[k] = 8'hFF;
            word_b[k] = 8'h00;
        end
        run_op(2'd0, 16, 1'b1, 1);
        chk("len_max_zero", last_z, 1);
        chk("len_max_carry", last_c, 1);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 16; k++) begin
                word_a[k] = 8'($urandom);
                word_b[k] = ($urandom_range(0, 7) == 0) ? word_a[k] : 8'($urandom);
            end
            run_op(2'($urandom), $urandom_range(1, 16), 1'($urandom), 1);
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 4'd3; cmd_cin = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_flags", {done_carry, done_zero, done_ovf}, 0);

        word_a[0] = 8'h00; word_b[0] = 8'h00;
        run_op(2'd0, 1, 1'b0, 0);
        chk("post_rst_data", last_data, 8'h00);
        chk("post_rst_zero", last_z, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
